// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: round-robin VC pick per input port, then
// round-robin input pick per output port, gated by downstream on/off flow control.
module switch_allocator #(
    parameter int unsigned PORT_NUM  = 5,
    parameter int unsigned VC_NUM    = 2,
    parameter int unsigned PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
    parameter int unsigned VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                 request_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0]  out_port_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]    downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]                 on_off_i,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]                 read_o,
    output logic [PORT_NUM-1:0][PORT_SIZE-1:0]              xbar_sel_o,
    output logic [PORT_NUM-1:0]                             valid_flit_o
);

    logic [PORT_NUM-1:0][VC_SIZE-1:0]   r_in_ptr;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] r_out_ptr;

    logic [PORT_NUM-1:0][VC_NUM-1:0]    w_elig;
    logic [PORT_NUM-1:0]                w_cand_valid;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_cand_vc;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_cand_port;
    logic [PORT_NUM-1:0]                w_win_valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_win_ip;

    // Out-of-range port encodings never index on_off_i and are simply ineligible.
    always_comb begin
        w_elig = '0;
        for (int unsigned ip = 0; ip < PORT_NUM; ip++) begin
            for (int unsigned v = 0; v < VC_NUM; v++) begin
                if (request_i[ip][v] && (32'(out_port_i[ip][v]) < PORT_NUM)) begin
                    w_elig[ip][v] = on_off_i[out_port_i[ip][v]][downstream_vc_i[ip][v]];
                end
            end
        end
    end

    always_comb begin
        int unsigned w_v;
        w_cand_valid = '0;
        w_cand_vc    = '0;
        w_cand_port  = '0;
        for (int unsigned ip = 0; ip < PORT_NUM; ip++) begin
            for (int unsigned k = 0; k < VC_NUM; k++) begin
                w_v = (32'(r_in_ptr[ip]) + k) % VC_NUM;
                if (!w_cand_valid[ip] && w_elig[ip][VC_SIZE'(w_v)]) begin
                    w_cand_valid[ip] = 1'b1;
                    w_cand_vc[ip]    = VC_SIZE'(w_v);
                    w_cand_port[ip]  = out_port_i[ip][VC_SIZE'(w_v)];
                end
            end
        end
    end

    always_comb begin
        int unsigned w_ip;
        w_win_valid = '0;
        w_win_ip    = '0;
        for (int unsigned op = 0; op < PORT_NUM; op++) begin
            for (int unsigned k = 0; k < PORT_NUM; k++) begin
                w_ip = (32'(r_out_ptr[op]) + k) % PORT_NUM;
                if (!w_win_valid[op] && w_cand_valid[PORT_SIZE'(w_ip)] &&
                    (32'(w_cand_port[PORT_SIZE'(w_ip)]) == op)) begin
                    w_win_valid[op] = 1'b1;
                    w_win_ip[op]    = PORT_SIZE'(w_ip);
                end
            end
        end
    end

    always_comb begin
        read_o       = '0;
        xbar_sel_o   = '0;
        valid_flit_o = '0;
        if (!rst) begin
            for (int unsigned op = 0; op < PORT_NUM; op++) begin
                if (w_win_valid[op]) begin
                    read_o[w_win_ip[op]][w_cand_vc[w_win_ip[op]]] = 1'b1;
                    xbar_sel_o[op]   = w_win_ip[op];
                    valid_flit_o[op] = 1'b1;
                end
            end
        end
    end

    // Only final winners advance; a stage-1 candidate that loses keeps its VC priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ptr  <= '0;
            r_out_ptr <= '0;
        end else begin
            for (int unsigned op = 0; op < PORT_NUM; op++) begin
                if (w_win_valid[op]) begin
                    r_out_ptr[op] <= PORT_SIZE'((32'(w_win_ip[op]) + 1) % PORT_NUM);
                    r_in_ptr[w_win_ip[op]] <=
                        VC_SIZE'((32'(w_cand_vc[w_win_ip[op]]) + 1) % VC_NUM);
                end
            end
        end
    end

endmodule
